// File: rtl/register_write_arbiter_if.sv
// register_write_arbiter_if: requester/bank bundle for register_write_arbiter; req_lock exists only with REG_ARB_LOCK_EN
interface register_write_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NUM_REQ = 4,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W = 3
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0] ack;
  logic [NUM_REGS-1:0] write_enable;
  logic [WIDTH-1:0] data_in;
  logic addr_err;
  logic busy;
`ifdef REG_ARB_LOCK_EN
  logic [NUM_REQ-1:0] req_lock;
  modport master (output req, req_addr, req_data, req_lock, input ack, write_enable, data_in, addr_err, busy);
  modport slave (input req, req_addr, req_data, req_lock, output ack, write_enable, data_in, addr_err, busy);
`else
  modport master (output req, req_addr, req_data, input ack, write_enable, data_in, addr_err, busy);
  modport slave (input req, req_addr, req_data, output ack, write_enable, data_in, addr_err, busy);
`endif
endinterface

// File: rtl/register_write_arbiter.sv
// register_write_arbiter: round-robin sharing of a register bank's write port; REG_ARB_LOCK_EN enables grant locking
module register_write_arbiter #(
  parameter int WIDTH = 16,
  parameter int NUM_REQ = 4,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W = 3
) (
  input logic clk,
  input logic reset_n,
  register_write_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] rr_ptr, win, win_nxt, cand;
  logic [PW:0] sum;
  logic [ADDR_W-1:0] addr_r, addr_sel;
  logic [WIDTH-1:0] data_r, data_sel;
  logic [NUM_REQ-1:0] elig;
  logic found, lock_hold, addr_ok;
  assign elig = bus.req & ~bus.ack;
`ifdef REG_ARB_LOCK_EN
  assign lock_hold = state == WRITE && bus.req[win] && bus.req_lock[win];
`else
  assign lock_hold = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      win <= '0;
      addr_r <= '0;
      data_r <= '0;
    end else begin
      state <= state_nxt;
      if (found) begin
        win <= win_nxt;
        addr_r <= addr_sel;
        data_r <= data_sel;
      end
      if (found && !lock_hold) rr_ptr <= win_nxt == PW'(NUM_REQ - 1) ? '0 : win_nxt + 1'b1;
    end
  // scan from rr_ptr with wrap; a held lock overrides the scan
  always_comb begin
    found = 1'b0;
    win_nxt = win;
    sum = '0;
    cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      cand = sum >= (PW+1)'(NUM_REQ) ? PW'(sum - (PW+1)'(NUM_REQ)) : sum[PW-1:0];
      if (!found && elig[cand]) begin
        found = 1'b1;
        win_nxt = cand;
      end
    end
    if (lock_hold) begin
      found = 1'b1;
      win_nxt = win;
    end
    state_nxt = found ? WRITE : IDLE;
  end
  always_comb begin
    addr_sel = '0;
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win_nxt == PW'(i)) begin
        addr_sel = bus.req_addr[i*ADDR_W +: ADDR_W];
        data_sel = bus.req_data[i*WIDTH +: WIDTH];
      end
  end
  always_comb begin
    addr_ok = {1'b0, addr_r} < (ADDR_W+1)'(NUM_REGS);
    bus.busy = state == WRITE;
    bus.ack = bus.busy ? NUM_REQ'(1) << win : '0;
    bus.write_enable = bus.busy && addr_ok ? NUM_REGS'(1) << addr_r : '0;
    bus.data_in = bus.busy ? data_r : '0;
    bus.addr_err = bus.busy && !addr_ok;
  end
endmodule
